// File: rtl/bcd_to_bin_if.sv
// Start/busy/done handshake bundle for the BCD-to-binary converter.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BIN_W  = 20
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output start, output bcd_in,
                  input  bin_out, input busy, input done, input err);
  modport slave  (input  start, input bcd_in,
                  output bin_out, output busy, output done, output err);
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble: packed BCD digits to binary, one bit per cycle.
// Optional illegal-digit detection enabled by defining BCD_TO_BIN_CHECK_EN.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BIN_W  = 20
) (
  input logic         clk,
  input logic         reset_n,
  bcd_to_bin_if.slave bus
);
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W);

  typedef enum logic [1:0] {IDLE, CONV, DONE, FAULT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  work_step_c;
  logic [BIN_W-1:0]   bin_out_q;
  logic               busy_q;
  logic               done_q;
  logic               bad_c;

  // One iteration: shift right, then pull back every BCD nibble that landed at >= 8.
  always_comb begin
    work_step_c = work >> 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_step_c[BIN_W + 4*i + 3])
        work_step_c[BIN_W + 4*i +: 4] = work_step_c[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  logic err_q;

  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
  end

  // Error flag only changes when a request is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      err_q <= 1'b0;
    else if (state == IDLE && bus.start) err_q <= bad_c;
  end

  assign bus.err = err_q;
`else
  assign bad_c   = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bad_c) begin
              state <= FAULT;
            end else begin
              work   <= {bus.bcd_in, BIN_W'(0)};
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= CONV;
            end
          end
        end
        CONV: begin
          work <= work_step_c;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bin_out_q <= work_step_c[BIN_W-1:0];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:  state <= IDLE;
        // Rejected request still completes the handshake with a zero result.
        FAULT: begin
          bin_out_q <= '0;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bin_out = bin_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
